// File: rtl/mem_lsu_ctrl.sv
// Memory-stage load/store controller: drives the data-cache handshake,
// formats store lanes and load results, and stalls the pipeline meanwhile.
module mem_lsu_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  EX_LdStFlag,
    input  logic [ADDR_WIDTH-1:0] EX_AluData,
    input  logic [DATA_WIDTH-1:0] EX_StData,
    input  logic [2:0]            IDEX_LdType,
    input  logic [1:0]            IDEX_StType,
    output logic                  Dcache_Req,
    output logic                  Dcache_We,
    output logic [ADDR_WIDTH-1:0] Dcache_Addr,
    output logic [DATA_WIDTH-1:0] Dcache_WrData,
    output logic [3:0]            Dcache_ByteEn,
    input  logic                  Dcache_Ready,
    input  logic                  Dcache_RspValid,
    input  logic [DATA_WIDTH-1:0] Dcache_RdData,
    input  logic                  Dcache_Err,
    output logic                  Mem_DcacheEN,
    output logic                  Mem_Stall,
    output logic [DATA_WIDTH-1:0] Mem_LdData,
    output logic                  Mem_MisalignExc,
    output logic                  Mem_AccessFault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LW  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;
    localparam logic [2:0] LD_LHU = 3'd5;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_wrdata;
    logic [3:0]            r_byteen;
    logic [2:0]            r_ldtype;
    logic [7:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_lddata;
    logic                  r_fault;
    logic                  r_mis;

    logic                  w_is_st;
    logic                  w_ld_ok;
    logic                  w_start;
    logic                  w_mis;
    logic                  w_tmo;
    logic [DATA_WIDTH-1:0] w_wrdata;
    logic [3:0]            w_byteen;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_ld_fmt;

    assign w_is_st = (IDEX_StType != 2'd0);
    assign w_ld_ok = (IDEX_LdType != 3'd0) && (IDEX_LdType <= LD_LHU);
    assign w_start = EX_LdStFlag && (w_is_st || w_ld_ok);
    assign w_tmo   = (r_cnt == 8'(TIMEOUT_CYCLES - 1));

    // A store wins when both types are set, so it alone decides alignment.
    always_comb begin
        w_mis = 1'b0;
        if (w_is_st) begin
            case (IDEX_StType)
                2'd2:    w_mis = EX_AluData[0];
                2'd3:    w_mis = |EX_AluData[1:0];
                default: w_mis = 1'b0;
            endcase
        end else begin
            case (IDEX_LdType)
                LD_LH, LD_LHU: w_mis = EX_AluData[0];
                LD_LW:         w_mis = |EX_AluData[1:0];
                default:       w_mis = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_wrdata = '0;
        w_byteen = 4'b0000;
        case (IDEX_StType)
            2'd1: begin
                w_wrdata = {4{EX_StData[7:0]}};
                w_byteen = 4'b0001 << EX_AluData[1:0];
            end
            2'd2: begin
                w_wrdata = {2{EX_StData[15:0]}};
                w_byteen = EX_AluData[1] ? 4'b1100 : 4'b0011;
            end
            2'd3: begin
                w_wrdata = EX_StData;
                w_byteen = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = Dcache_RdData[7:0];
        case (r_addr[1:0])
            2'd1:    w_byte = Dcache_RdData[15:8];
            2'd2:    w_byte = Dcache_RdData[23:16];
            2'd3:    w_byte = Dcache_RdData[31:24];
            default: w_byte = Dcache_RdData[7:0];
        endcase
        w_half = r_addr[1] ? Dcache_RdData[31:16] : Dcache_RdData[15:0];
        case (r_ldtype)
            LD_LB:   w_ld_fmt = {{24{w_byte[7]}}, w_byte};
            LD_LH:   w_ld_fmt = {{16{w_half[15]}}, w_half};
            LD_LW:   w_ld_fmt = Dcache_RdData;
            LD_LBU:  w_ld_fmt = {24'd0, w_byte};
            LD_LHU:  w_ld_fmt = {16'd0, w_half};
            default: w_ld_fmt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next = w_mis ? S_DONE : S_REQ;
            end
            S_REQ: begin
                if (Dcache_Ready) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (Dcache_RspValid || w_tmo) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wrdata <= '0;
            r_byteen <= 4'b0000;
            r_ldtype <= 3'd0;
            r_cnt    <= 8'd0;
            r_lddata <= '0;
            r_fault  <= 1'b0;
            r_mis    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr   <= EX_AluData;
                        r_we     <= w_is_st;
                        r_wrdata <= w_wrdata;
                        r_byteen <= w_byteen;
                        r_ldtype <= w_is_st ? 3'd0 : IDEX_LdType;
                        r_mis    <= w_mis;
                        r_fault  <= 1'b0;
                        if (w_mis) r_lddata <= '0;
                    end
                end
                S_REQ: begin
                    if (Dcache_Ready) r_cnt <= 8'd0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (Dcache_RspValid) begin
                        r_fault  <= Dcache_Err;
                        r_lddata <= Dcache_Err ? '0 : w_ld_fmt;
                    end else if (w_tmo) begin
                        r_fault  <= 1'b1;
                        r_lddata <= '0;
                    end
                end
                default: begin
                    r_mis   <= 1'b0;
                    r_fault <= 1'b0;
                end
            endcase
        end
    end

    assign Dcache_Req      = (r_state == S_REQ);
    assign Dcache_We       = r_we;
    assign Dcache_Addr     = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign Dcache_WrData   = r_wrdata;
    assign Dcache_ByteEn   = r_byteen;
    assign Mem_DcacheEN    = (r_state == S_DONE);
    assign Mem_LdData      = r_lddata;
    assign Mem_MisalignExc = (r_state == S_DONE) && r_mis;
    assign Mem_AccessFault = (r_state == S_DONE) && r_fault;
    // Reset gates the combinational IDLE term so the stall drops at once.
    assign Mem_Stall = rst_n && (((r_state == S_IDLE) && w_start)
                     || (r_state == S_REQ) || (r_state == S_WAIT));

endmodule

// File: doc/mem_lsu_ctrl.md
Name: mem_lsu_ctrl

Overview:
Memory-stage load/store controller. It is the consumer of the execute stage's EX_LdStFlag and the producer of the Mem_DcacheEN completion strobe that clears that flag.
- Takes the effective address (EX_AluData), store data and the load/store type.
- Runs a request/response handshake with the data cache.
- Aligns store data and byte enables; extracts and extends load data.
- Stalls the pipeline until the access completes.

Parameters:
ADDR_WIDTH, 32, address width (matches `ADDR_WIDTH)
DATA_WIDTH, 32, data width (matches `DATA_WIDTH)
TIMEOUT_CYCLES, 255, max cycles in WAIT before an access fault is reported; range 1..255

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
EX_LdStFlag  in  1  load/store pending from execute stage
EX_AluData  in  32  effective address
EX_StData  in  32  store data (forwarded rs2)
IDEX_LdType  in  3  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, others none
IDEX_StType  in  2  0 none, 1 SB, 2 SH, 3 SW
Dcache_Req  out  1  request valid
Dcache_We  out  1  1 = write
Dcache_Addr  out  32  word-aligned address {addr[31:2],2'b00}
Dcache_WrData  out  32  lane-replicated store data
Dcache_ByteEn  out  4  byte write enables (4'b0000 on reads)
Dcache_Ready  in  1  cache accepts request this cycle
Dcache_RspValid  in  1  response/ack valid
Dcache_RdData  in  32  read word
Dcache_Err  in  1  bus error, qualified by RspValid
Mem_DcacheEN  out  1  one-cycle access-complete strobe
Mem_Stall  out  1  hold IF/ID/EX
Mem_LdData  out  32  formatted load result; held until next completion
Mem_MisalignExc  out  1  one-cycle pulse with Mem_DcacheEN
Mem_AccessFault  out  1  one-cycle pulse with Mem_DcacheEN

Behaviour:
- Reset (asynchronous, any state): state IDLE; all outputs 0; captured registers and timeout counter cleared.

States:
- IDLE:
  - On EX_LdStFlag=1, capture address, store data and type.
  - If any type is nonzero: go to REQ, or to DONE with misalign set.
  - If both types are zero: ignore the flag, stay in IDLE, drive Mem_Stall=0.
- REQ:
  - Dcache_Req=1; address, data, byte enables and write flag are stable from registers.
  - On Dcache_Ready=1, go to WAIT and clear the timeout counter.
  - Req stays asserted until Ready; there is no timeout in REQ.
- WAIT:
  - Dcache_Req=0; the counter increments each cycle.
  - On Dcache_RspValid=1, capture the result and Err, then go to DONE.
  - When the counter reaches TIMEOUT_CYCLES, go to DONE with fault set.
  - A RspValid arriving in the same cycle as the timeout wins.
- DONE:
  - Mem_DcacheEN=1 for exactly one cycle; Mem_Stall=0; fault/misalign pulses asserted here.
  - Return to IDLE.

Cycle-level rules:
- Mem_Stall = (IDLE & EX_LdStFlag & type nonzero) | REQ | WAIT. The IDLE term is combinational.
- Minimum load/store latency, flag to Mem_DcacheEN: 3 cycles (IDLE -> REQ with Ready=1 -> WAIT with RspValid=1 -> DONE).
- RspValid is only sampled in WAIT, so a response in the Ready cycle is not seen.
- Stores also wait for RspValid as a write acknowledge.

Type priority and alignment:
- If LdType and StType are both nonzero, the access is a store.
- Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
- A misaligned access issues no cache request: IDLE -> DONE with Mem_MisalignExc=1.
- On misalign or fault, Mem_LdData=0.

Store formatting:
- SB: WrData={4{d[7:0]}}, ByteEn=4'b0001<<addr[1:0].
- SH: WrData={2{d[15:0]}}, ByteEn=addr[1]?4'b1100:4'b0011.
- SW: WrData=d, ByteEn=4'b1111.

Load formatting:
- Select the byte lane by addr[1:0] and the halfword by addr[1].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.

Error and pipeline interlock:
- Dcache_Err=1 with RspValid: Mem_AccessFault=1 and Mem_LdData=0.
- In DONE, the execute stage deasserts EX_LdStFlag (gated by Mem_DcacheEN), so a new access cannot start in the DONE cycle.
- A new access can start the cycle after DONE.

Test Plan:
- LW addr 0x1000_0008, Ready on first REQ cycle, RspValid next cycle with RdData 0xDEAD_BEEF -> Addr 0x1000_0008, ByteEn 0, Mem_LdData 0xDEAD_BEEF, Mem_DcacheEN 3 cycles after flag, Stall high 3 cycles.
- LB addr 0x...03 with RdData 0x80FF_FF7F -> Mem_LdData 0xFFFF_FF80; LBU -> 0x0000_0080; LHU addr 0x...02 -> 0x0000_80FF.
- SB addr 0x...02 data 0x1234_56AB -> WrData 0xABAB_ABAB, ByteEn 4'b0100, We=1; Ready withheld 4 cycles -> Req held, completion delayed 4 cycles.
- SW addr 0x...06 -> no Dcache_Req; Mem_MisalignExc and Mem_DcacheEN pulse together 1 cycle after flag.
- TIMEOUT_CYCLES=4, no RspValid -> Mem_AccessFault pulse after 4 WAIT cycles; Dcache_Err=1 with RspValid -> fault pulse, LdData 0.
- rst_n low during WAIT -> all outputs 0 immediately; after release, a new LW completes normally.
